clk_step_ctrl: RTL
==================

Name: clk_step_ctrl

Overview:
Run/halt/single-step controller that sequences the Lipsi processor from the 100 MHz board clock. Replaces the free-running slow clock with a one-cycle clock enable (cpu_en) at a rate selected from four terminal counts, plus debounced single-step from a push button. Also drives a 50% duty display clock (clklow) and a saturating executed-instruction counter. The processor core runs on clk and advances only when cpu_en=1.

Parameters:
CNT_W, 26, width of the rate counter
DIV0, 499_999, terminal count for div_sel=0 (tick every DIV0+1 cycles)
DIV1, 4_999_999, terminal count for div_sel=1
DIV2, 49_999, terminal count for div_sel=2
DIV3, 0, terminal count for div_sel=3 (tick every cycle, full speed)
DB_CNT, 250_000, cycles a synchronized button level must be stable before it is accepted (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
run_sw  input  1  run switch, asynchronous (1=run, 0=halt)
step_btn  input  1  single-step push button, asynchronous, bouncy
div_sel  input  2  rate select, synchronous to clk
halted_in  input  1  processor halt flag, synchronous to clk
cpu_en  output  1  one-cycle processor advance enable
clklow  output  1  display clock, toggles on every tick
state  output  2  FSM state: 00 HALT, 01 RUN, 10 STEP
step_count  output  16  number of cpu_en pulses issued, saturating

Behaviour:
- Async active-high reset: all flops cleared. cpu_en=0, clklow=0, state=HALT, step_count=0, rate counter=0, sync/debounce flops=0, debounced level=0.
- run_sw: 2-flop synchronizer gives run_s. step_btn: 2-flop synchronizer, then debouncer:
  - The debounce counter resets whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments. When it reaches DB_CNT-1, the debounced level takes the synchronized value and the counter clears.
  - step_pulse = 1 for one cycle on a 0->1 edge of the debounced level.
- Rate counter:
  - TC = DIV[div_sel], sampled every cycle.
  - If count >= TC: count<=0 and tick=1 for that cycle. Otherwise count<=count+1.
  - Because of the >= compare, lowering TC mid-count wraps on the next cycle with no overrun.
  - clklow toggles on every tick in all states.
- FSM (registered; transitions take effect next cycle):
  - HALT: cpu_en=0.
    - run_s=1 and halted_in=0 -> RUN; the rate counter is cleared to 0 on this transition.
    - Else step_pulse=1 and halted_in=0 -> STEP.
    - Run has priority over step.
  - RUN: cpu_en = tick & ~halted_in (combinational from the current tick).
    - run_s=0 or halted_in=1 -> HALT.
    - step_pulse is ignored.
  - STEP: cpu_en=1 for exactly this one cycle, then -> HALT unconditionally.
  - First cpu_en after entering RUN occurs TC+1 cycles after the RUN entry cycle.
- step_count increments on each cycle with cpu_en=1 and holds at 16'hFFFF.
- halted_in=1 in the same cycle as a tick in RUN: no cpu_en, and the FSM goes to HALT.
- Reset mid-operation (any state, any count) returns everything to reset values immediately. No cpu_en is generated from stale state after reset deassertion.
- div_sel change in RUN: no state change; the new period applies from the next wrap (or immediately if count >= new TC).

Test Plan:
- Bench params DIV0=3, DIV1=7, DIV2=1, DIV3=0, DB_CNT=4.
- Reset asserted mid-count in RUN -> cpu_en=0, clklow=0, state=00, step_count=0 in the same cycle; the FSM stays HALT after release with run_sw=0.
- run_sw=1, div_sel=0, halted_in=0 -> state=01 three cycles after run_sw rises (2 sync + 1 FSM). cpu_en pulses every 4 cycles, first at entry+4. clklow period is 8 cycles. After 10 pulses, step_count=10.
- Step button bouncing 1,0,1,0 each for 2 cycles, then held 1 -> exactly one STEP visit and one cpu_en pulse; step_count increments by 1; state 10 -> 00.
- In RUN with div_sel=1 (count at 6), switch div_sel=2 -> tick on the next cycle; the period is 2 thereafter. With div_sel=3, cpu_en is continuously 1.
- In RUN, assert halted_in coincident with a tick -> no cpu_en that cycle, state=00 next cycle. A step press while halted_in=1 is ignored.
- Force step_count to 16'hFFFE via a long DIV3 run -> after 2 more pulses it holds at 16'hFFFF.

Source files
------------

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: run/halt/single-step clock-enable sequencer for the Lipsi core
module clk_step_ctrl #(
  parameter int CNT_W  = 26,
  parameter int DIV0   = 499_999,
  parameter int DIV1   = 4_999_999,
  parameter int DIV2   = 49_999,
  parameter int DIV3   = 0,
  parameter int DB_CNT = 250_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic [1:0]  div_sel,
  input  logic        halted_in,
  output logic        cpu_en,
  output logic        clklow,
  output logic [1:0]  state,
  output logic [15:0] step_count
);
  localparam int DB_W = $clog2(DB_CNT + 1);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10} state_t;
  state_t st;
  logic run_m, run_s, btn_m, btn_s, db_lvl, db_prev, db_hit, tick, step_pulse, go_run;
  logic [DB_W-1:0] db_cnt;
  logic [CNT_W-1:0] cnt, tc;
  always_comb begin
    tc = div_sel == 2'd0 ? CNT_W'(DIV0) : div_sel == 2'd1 ? CNT_W'(DIV1) :
         div_sel == 2'd2 ? CNT_W'(DIV2) : CNT_W'(DIV3);
    tick = cnt >= tc;
    db_hit = (btn_s != db_lvl) && (db_cnt == DB_W'(DB_CNT - 1));
    step_pulse = db_lvl & ~db_prev;
    go_run = (st == HALT) & run_s & ~halted_in;
    cpu_en = (st == STEP) | ((st == RUN) & tick & ~halted_in);
  end
  assign state = st;
  // Button level is accepted only after DB_CNT consecutive cycles of disagreement
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {run_m, run_s, btn_m, btn_s, db_lvl, db_prev} <= '0;
      db_cnt <= '0;
    end else begin
      run_m <= run_sw;
      run_s <= run_m;
      btn_m <= step_btn;
      btn_s <= btn_m;
      db_prev <= db_lvl;
      db_lvl <= db_hit ? btn_s : db_lvl;
      db_cnt <= (btn_s == db_lvl || db_hit) ? '0 : db_cnt + 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      clklow <= 1'b0;
    end else begin
      cnt <= (go_run | tick) ? '0 : cnt + 1'b1;
      clklow <= clklow ^ tick;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= HALT;
      step_count <= '0;
    end else begin
      st <= st == HALT ? (go_run ? RUN : (step_pulse & ~halted_in) ? STEP : HALT) :
            st == RUN ? ((run_s & ~halted_in) ? RUN : HALT) : HALT;
      step_count <= step_count + 16'(cpu_en & ~&step_count);
    end
endmodule
